axi_master_arbiter: RTL and testbench
=====================================

# axi_master_arbiter

Shares the single AXI3 master port of the CPU between the instruction-fetch interface (requester 0, read-only) and the data-memory interface (requester 1, read/write). Read requests are arbitrated round-robin, with one outstanding read in flight. The data write channels pass straight through. A read-after-write guard holds data reads until the data write response has returned. The block sits between the two RAM interfaces and the SoC AXI crossbar.

## Interface
Parameters:
- `ID_INST`, 4'h0: ARID driven for requester-0 reads.
- `ID_DATA`, 4'h1: ARID/AWID/WID driven for requester-1 traffic.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `s0_araddr/s0_arlen/s0_arsize/s0_arburst` in 32/8/3/2: instruction-fetch read address fields.
- `s0_arvalid` in 1 / `s0_arready` out 1: instruction-fetch AR handshake.
- `s0_rdata` out 32, `s0_rresp` out 2, `s0_rlast` out 1, `s0_rvalid` out 1, `s0_rready` in 1: instruction-fetch R channel.
- `s1_ar*`, `s1_r*`: same set as requester 0, for data reads.
- `s1_aw{addr,len,size,burst,valid}` in 32/8/3/2/1, `s1_awready` out 1: data write address.
- `s1_w{data,strb,last,valid}` in 32/4/1/1, `s1_wready` out 1: data write data.
- `s1_bresp` out 2, `s1_bvalid` out 1, `s1_bready` in 1: data write response.
- `m_ar{id,addr,len,size,burst,lock,cache,prot,valid}` out 4/32/8/3/2/2/4/3/1, `m_arready` in 1: master AR.
- `m_r{id,data,resp,last,valid}` in 4/32/2/1/1, `m_rready` out 1: master R.
- `m_aw*`, `m_w*` (including `m_wid`) out, `m_awready`/`m_wready` in, `m_b{id,resp,valid}` in, `m_bready` out: master write channels.
- `rid_err` out 1: sticky flag, set when a read beat arrives with RID ≠ granted ID.

## Operation
- Read FSM states:
  - IDLE: grant a requester.
  - AR_SEND: drive `m_arvalid` until `m_arready`.
  - R_WAIT: route R beats until the last beat.
- IDLE arbitration:
  - Eligible: `s0_arvalid`; `s1_arvalid && !wr_busy`.
  - Both eligible: the requester not granted last time wins (`last_grant` register, reset value 0, so data wins the first tie).
  - The winner's `s*_arready` is asserted combinationally in IDLE. On that handshake the AR fields are latched and `grant` is stored, then → AR_SEND.
  - Latched constants: `m_arid` = ID of the granted requester; `m_arlock`=0, `m_arcache`=0, `m_arprot`=0.
- AR_SEND: `m_arvalid`=1 with the latched fields. On `m_arready` → R_WAIT.
- R_WAIT:
  - Granted requester: `s*_rvalid`=`m_rvalid`, `m_rready`=its `s*_rready`, and rdata/rresp/rlast pass through.
  - Other requester: `s*_rvalid`=0.
  - On the `m_rvalid && m_rready && m_rlast` handshake → IDLE.
  - A beat with `m_rid` ≠ granted ID is still forwarded and sets `rid_err`.
- Write path:
  - AW/W/B are combinational pass-through; `m_awid`/`m_wid` are tied to `ID_DATA`.
  - `wr_busy` sets on the AW handshake and clears on the B handshake. The B handshake has priority if both occur in the same cycle.
- Reset mid-transaction: everything returns to IDLE. No attempt is made to complete in-flight bursts; the system resets together.

## Timing
- Reset values:
  - State IDLE, `grant`=0, `last_grant`=0, `wr_busy`=0, `rid_err`=0.
  - All `*valid`/`*ready` outputs 0 while reset is asserted. Pass-through valids are gated by `!reset`.
  - Latched AR fields reset to 0.
- Read latency: s* AR handshake in cycle N; `m_arvalid` high from N+1. R beats pass through with zero cycles of added latency.
- Minimum gap: after the RLAST handshake in cycle M, the next grant is possible in M+1.
- A data read is eligible no earlier than the cycle after the B handshake.
- `s*_arready` is never high outside IDLE.

## Structure
- Shared `axi_defs` include holds:
  - `BURST_INCR`=2'b01.
  - ID constants.
  - The read FSM state encodings (IDLE=2'd0, AR_SEND=2'd1, R_WAIT=2'd2).
- One sub-module, `rr_arb2`: a two-input round-robin arbiter with combinational `req[1:0]` → `gnt[1:0]` and a registered last-grant update on `accept`.

## Test plan
- Single instruction read: `s0_araddr`=0xBFC00000, len 0, with `m_arready` delayed 3 cycles → `m_arid`=0, `m_arvalid` held 4 cycles, and `s0_rdata` equals `m_rdata` 0x3C080001 on the same cycle.
- Both requesters raise arvalid in the same cycle after reset → data granted first (ARID 1); instruction granted in the cycle after data RLAST.
- Burst of 4 beats on requester 0 while requester 1 requests → `s1_arready` stays 0 until after beat 4; no R beat reaches requester 1.
- Data write to 0x80001000, then a data read of the same address issued 1 cycle later → read is held until the cycle after `m_bvalid && m_bready`. An instruction read issued during `wr_busy` is granted immediately.
- `m_rid`=3 injected during R_WAIT → beat forwarded and `rid_err`=1, sticky until reset.
- Reset asserted in AR_SEND → next cycle: state IDLE, `m_arvalid`=0, all `s*_arready`=0.

Source files
------------

// File: rtl/axi_master_arbiter_pkg.sv
// Shared AXI definitions for the CPU master-port arbiter:
// burst/ID constants, read FSM encodings and the latched AR bundle.
package axi_master_arbiter_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [3:0] ID_INST_DEF = 4'h0;
  localparam logic [3:0] ID_DATA_DEF = 4'h1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    AR_SEND = 2'd1,
    R_WAIT  = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_req_t;

endpackage

// File: rtl/axi_master_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; the last-grant pointer only
// advances when the offered grant is actually accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11): gnt = last_grant ? 2'b01 : 2'b10;
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default:        gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b0;
    end else if (accept) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/axi_master_arbiter.sv
// Shares the CPU AXI3 master port between instruction fetch (0)
// and data (1): round-robin single-outstanding reads, write pass-through.
module axi_master_arbiter
  import axi_master_arbiter_pkg::*;
#(
  parameter logic [3:0] ID_INST = ID_INST_DEF,
  parameter logic [3:0] ID_DATA = ID_DATA_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s0_araddr,
  input  logic [7:0]  s0_arlen,
  input  logic [2:0]  s0_arsize,
  input  logic [1:0]  s0_arburst,
  input  logic        s0_arvalid,
  output logic        s0_arready,
  output logic [31:0] s0_rdata,
  output logic [1:0]  s0_rresp,
  output logic        s0_rlast,
  output logic        s0_rvalid,
  input  logic        s0_rready,
  input  logic [31:0] s1_araddr,
  input  logic [7:0]  s1_arlen,
  input  logic [2:0]  s1_arsize,
  input  logic [1:0]  s1_arburst,
  input  logic        s1_arvalid,
  output logic        s1_arready,
  output logic [31:0] s1_rdata,
  output logic [1:0]  s1_rresp,
  output logic        s1_rlast,
  output logic        s1_rvalid,
  input  logic        s1_rready,
  input  logic [31:0] s1_awaddr,
  input  logic [7:0]  s1_awlen,
  input  logic [2:0]  s1_awsize,
  input  logic [1:0]  s1_awburst,
  input  logic        s1_awvalid,
  output logic        s1_awready,
  input  logic [31:0] s1_wdata,
  input  logic [3:0]  s1_wstrb,
  input  logic        s1_wlast,
  input  logic        s1_wvalid,
  output logic        s1_wready,
  output logic [1:0]  s1_bresp,
  output logic        s1_bvalid,
  input  logic        s1_bready,
  output logic [3:0]  m_arid,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic [1:0]  m_arlock,
  output logic [3:0]  m_arcache,
  output logic [2:0]  m_arprot,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [3:0]  m_rid,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic [3:0]  m_awid,
  output logic [31:0] m_awaddr,
  output logic [7:0]  m_awlen,
  output logic [2:0]  m_awsize,
  output logic [1:0]  m_awburst,
  output logic [1:0]  m_awlock,
  output logic [3:0]  m_awcache,
  output logic [2:0]  m_awprot,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [3:0]  m_wid,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wlast,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [3:0]  m_bid,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic        rid_err
);

  rd_state_e state;
  logic      grant;
  logic      wr_busy;
  ar_req_t   ar_q;
  ar_req_t   ar_d;
  logic [1:0] req;
  logic [1:0] gnt;
  logic      idle;
  logic      accept;
  logic      r_fire;
  logic      aw_fire;
  logic      b_fire;
  logic [3:0] grant_id;
  logic      unused;

  assign unused = ^m_bid;

  assign idle = (state == IDLE) && !reset;
  assign req  = idle ? {s1_arvalid && !wr_busy, s0_arvalid}
                     : 2'b00;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .accept (accept),
    .gnt    (gnt)
  );

  assign s0_arready = gnt[0];
  assign s1_arready = gnt[1];
  assign accept     = |gnt;

  always_comb begin
    ar_d = '0;
    unique case (1'b1)
      gnt[1]: ar_d = '{ID_DATA, s1_araddr, s1_arlen,
                       s1_arsize, s1_arburst};
      gnt[0]: ar_d = '{ID_INST, s0_araddr, s0_arlen,
                       s0_arsize, s0_arburst};
      default: ar_d = '0;
    endcase
  end

  assign grant_id = grant ? ID_DATA : ID_INST;
  assign r_fire   = m_rvalid && m_rready && m_rlast;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= 1'b0;
      ar_q    <= '0;
      rid_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            ar_q  <= ar_d;
            grant <= gnt[1];
            state <= AR_SEND;
          end
        end
        AR_SEND: begin
          if (m_arready) state <= R_WAIT;
        end
        R_WAIT: begin
          // mismatched RID is still forwarded; only flagged
          if (m_rvalid && m_rid != grant_id) rid_err <= 1'b1;
          if (r_fire) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m_arid    = ar_q.id;
  assign m_araddr  = ar_q.addr;
  assign m_arlen   = ar_q.len;
  assign m_arsize  = ar_q.size;
  assign m_arburst = ar_q.burst;
  assign m_arlock  = 2'b00;
  assign m_arcache = 4'h0;
  assign m_arprot  = 3'b000;
  assign m_arvalid = (state == AR_SEND) && !reset;

  always_comb begin
    s0_rvalid = 1'b0;
    s1_rvalid = 1'b0;
    m_rready  = 1'b0;
    if (state == R_WAIT && !reset) begin
      s0_rvalid = m_rvalid && !grant;
      s1_rvalid = m_rvalid && grant;
      m_rready  = grant ? s1_rready : s0_rready;
    end
  end

  assign s0_rdata = m_rdata;
  assign s0_rresp = m_rresp;
  assign s0_rlast = m_rlast;
  assign s1_rdata = m_rdata;
  assign s1_rresp = m_rresp;
  assign s1_rlast = m_rlast;

  assign m_awid    = ID_DATA;
  assign m_awaddr  = s1_awaddr;
  assign m_awlen   = s1_awlen;
  assign m_awsize  = s1_awsize;
  assign m_awburst = s1_awburst;
  assign m_awlock  = 2'b00;
  assign m_awcache = 4'h0;
  assign m_awprot  = 3'b000;
  assign m_awvalid = s1_awvalid && !reset;
  assign s1_awready = m_awready && !reset;

  assign m_wid    = ID_DATA;
  assign m_wdata  = s1_wdata;
  assign m_wstrb  = s1_wstrb;
  assign m_wlast  = s1_wlast;
  assign m_wvalid = s1_wvalid && !reset;
  assign s1_wready = m_wready && !reset;

  assign s1_bresp  = m_bresp;
  assign s1_bvalid = m_bvalid && !reset;
  assign m_bready  = s1_bready && !reset;

  assign aw_fire = m_awvalid && m_awready;
  assign b_fire  = m_bvalid && m_bready;

  // B wins over AW so a same-cycle pair leaves no stale busy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_busy <= 1'b0;
    end else if (b_fire) begin
      wr_busy <= 1'b0;
    end else if (aw_fire) begin
      wr_busy <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed bench for axi_master_arbiter: arbitration table plus
// hand-written multi-cycle sequences for the corner cases.
module tb_axi_master_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s0_araddr;
  logic [7:0]  s0_arlen;
  logic [2:0]  s0_arsize;
  logic [1:0]  s0_arburst;
  logic        s0_arvalid, s0_arready;
  logic [31:0] s0_rdata;
  logic [1:0]  s0_rresp;
  logic        s0_rlast, s0_rvalid, s0_rready;
  logic [31:0] s1_araddr;
  logic [7:0]  s1_arlen;
  logic [2:0]  s1_arsize;
  logic [1:0]  s1_arburst;
  logic        s1_arvalid, s1_arready;
  logic [31:0] s1_rdata;
  logic [1:0]  s1_rresp;
  logic        s1_rlast, s1_rvalid, s1_rready;
  logic [31:0] s1_awaddr;
  logic [7:0]  s1_awlen;
  logic [2:0]  s1_awsize;
  logic [1:0]  s1_awburst;
  logic        s1_awvalid, s1_awready;
  logic [31:0] s1_wdata;
  logic [3:0]  s1_wstrb;
  logic        s1_wlast, s1_wvalid, s1_wready;
  logic [1:0]  s1_bresp;
  logic        s1_bvalid, s1_bready;
  logic [3:0]  m_arid;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst, m_arlock;
  logic [3:0]  m_arcache;
  logic [2:0]  m_arprot;
  logic        m_arvalid, m_arready;
  logic [3:0]  m_rid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast, m_rvalid, m_rready;
  logic [3:0]  m_awid;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst, m_awlock;
  logic [3:0]  m_awcache;
  logic [2:0]  m_awprot;
  logic        m_awvalid, m_awready;
  logic [3:0]  m_wid;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast, m_wvalid, m_wready;
  logic [3:0]  m_bid;
  logic [1:0]  m_bresp;
  logic        m_bvalid, m_bready;
  logic        rid_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_master_arbiter dut (
    .clk(clk), .reset(reset),
    .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
    .s0_arsize(s0_arsize), .s0_arburst(s0_arburst),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rresp(s0_rresp),
    .s0_rlast(s0_rlast), .s0_rvalid(s0_rvalid),
    .s0_rready(s0_rready),
    .s1_araddr(s1_araddr), .s1_arlen(s1_arlen),
    .s1_arsize(s1_arsize), .s1_arburst(s1_arburst),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rresp(s1_rresp),
    .s1_rlast(s1_rlast), .s1_rvalid(s1_rvalid),
    .s1_rready(s1_rready),
    .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen),
    .s1_awsize(s1_awsize), .s1_awburst(s1_awburst),
    .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
    .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
    .s1_wlast(s1_wlast), .s1_wvalid(s1_wvalid),
    .s1_wready(s1_wready),
    .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid),
    .s1_bready(s1_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arlock(m_arlock), .m_arcache(m_arcache),
    .m_arprot(m_arprot), .m_arvalid(m_arvalid),
    .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awlock(m_awlock), .m_awcache(m_awcache),
    .m_awprot(m_awprot), .m_awvalid(m_awvalid),
    .m_awready(m_awready),
    .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
    .m_bready(m_bready),
    .rid_err(rid_err)
  );

  typedef struct {
    logic s0;
    logic s1;
    logic rdy0;
    logic rdy1;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_r();
    m_rvalid = 0; m_rlast = 0; m_rid = 0; m_rdata = 0;
    s0_rready = 0; s1_rready = 0;
  endtask

  initial begin
    tbl[0] = '{1, 1, 0, 1};
    tbl[1] = '{1, 1, 1, 0};
    tbl[2] = '{1, 0, 1, 0};
    tbl[3] = '{1, 1, 0, 1};
    tbl[4] = '{0, 1, 0, 1};
    tbl[5] = '{1, 1, 1, 0};
    tbl[6] = '{0, 0, 0, 0};

    reset = 1;
    s0_araddr = 0; s0_arlen = 0; s0_arsize = 3'd2;
    s0_arburst = 2'b01; s0_arvalid = 0; s0_rready = 0;
    s1_araddr = 0; s1_arlen = 0; s1_arsize = 3'd2;
    s1_arburst = 2'b01; s1_arvalid = 0; s1_rready = 0;
    s1_awaddr = 0; s1_awlen = 0; s1_awsize = 3'd2;
    s1_awburst = 2'b01; s1_awvalid = 0;
    s1_wdata = 0; s1_wstrb = 0; s1_wlast = 0; s1_wvalid = 0;
    s1_bready = 0;
    m_arready = 0; m_rid = 0; m_rdata = 0; m_rresp = 0;
    m_rlast = 0; m_rvalid = 0; m_awready = 0; m_wready = 0;
    m_bid = 0; m_bresp = 0; m_bvalid = 0;

    step(); step();
    s0_arvalid = 1; s1_arvalid = 1; s1_awvalid = 1;
    m_bvalid = 1;
    #1;
    chk("rst_s0_arready", s0_arready, 0);
    chk("rst_s1_arready", s1_arready, 0);
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_m_awvalid", m_awvalid, 0);
    chk("rst_s1_bvalid", s1_bvalid, 0);
    chk("rst_rid_err", rid_err, 0);
    s0_arvalid = 0; s1_arvalid = 0; s1_awvalid = 0;
    m_bvalid = 0;
    reset = 0;
    step();

    // arbitration table, each granted read run to completion
    for (int r = 0; r < 7; r++) begin
      s0_arvalid = tbl[r].s0;
      s1_arvalid = tbl[r].s1;
      s0_araddr = 32'h1000_0000 + r;
      s1_araddr = 32'h2000_0000 + r;
      #1;
      chk($sformatf("tbl%0d_s0_arready", r), s0_arready,
          tbl[r].rdy0);
      chk($sformatf("tbl%0d_s1_arready", r), s1_arready,
          tbl[r].rdy1);
      if (tbl[r].rdy0 || tbl[r].rdy1) begin
        step();
        chk($sformatf("tbl%0d_arready_busy", r),
            {s0_arready, s1_arready}, 0);
        s0_arvalid = 0; s1_arvalid = 0;
        #1;
        chk($sformatf("tbl%0d_m_arvalid", r), m_arvalid, 1);
        chk($sformatf("tbl%0d_m_arid", r), m_arid,
            tbl[r].rdy1 ? 32'd1 : 32'd0);
        chk($sformatf("tbl%0d_m_araddr", r), m_araddr,
            tbl[r].rdy1 ? 32'h2000_0000 + r
                        : 32'h1000_0000 + r);
        m_arready = 1;
        step();
        m_arready = 0;
        m_rvalid = 1; m_rlast = 1;
        m_rid = tbl[r].rdy1 ? 4'h1 : 4'h0;
        m_rdata = 32'hA5A5_0000 + r;
        s0_rready = 1; s1_rready = 1;
        #1;
        chk($sformatf("tbl%0d_s0_rvalid", r), s0_rvalid,
            tbl[r].rdy0);
        chk($sformatf("tbl%0d_s1_rvalid", r), s1_rvalid,
            tbl[r].rdy1);
        chk($sformatf("tbl%0d_m_rready", r), m_rready, 1);
        step();
        clear_r();
      end else begin
        step();
        s0_arvalid = 0; s1_arvalid = 0;
      end
    end

    // single fetch with AR ready delayed 3 cycles
    begin
      int cnt;
      s0_araddr = 32'hBFC0_0000; s0_arlen = 0;
      s0_arvalid = 1;
      #1;
      chk("a_s0_arready", s0_arready, 1);
      step();
      s0_arvalid = 0;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
        #1;
        if (m_arvalid) cnt++;
        if (i == 3) m_arready = 1;
        step();
      end
      m_arready = 0;
      #1;
      chk("a_arvalid_cycles", cnt, 4);
      chk("a_arvalid_low", m_arvalid, 0);
      m_rvalid = 1; m_rlast = 1; m_rid = 0;
      m_rdata = 32'h3C08_0001; s0_rready = 1;
      #1;
      chk("a_s0_rdata", s0_rdata, 32'h3C08_0001);
      chk("a_s0_rvalid", s0_rvalid, 1);
      chk("a_s1_rvalid", s1_rvalid, 0);
      step();
      clear_r();
    end

    // 4-beat fetch burst while data requester waits
    s0_arlen = 8'd3; s0_arvalid = 1;
    #1;
    step();
    s0_arvalid = 0; s1_arvalid = 1;
    s1_araddr = 32'h8000_0040; m_arready = 1;
    #1;
    chk("b_s1_arready_ar", s1_arready, 0);
    step();
    m_arready = 0;
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1; m_rlast = (b == 3);
      m_rdata = 32'h100 + b; m_rid = 0;
      s0_rready = 1; s1_rready = 1;
      #1;
      chk($sformatf("b%0d_s1_rvalid", b), s1_rvalid, 0);
      chk($sformatf("b%0d_s1_arready", b), s1_arready, 0);
      chk($sformatf("b%0d_s0_rvalid", b), s0_rvalid, 1);
      step();
    end
    clear_r();
    #1;
    chk("b_s1_arready_after", s1_arready, 1);
    step();
    s1_arvalid = 0; m_arready = 1;
    #1;
    chk("b_m_arid", m_arid, 1);
    step();
    m_arready = 0;
    m_rvalid = 1; m_rlast = 1; m_rid = 1; s1_rready = 1;
    step();
    clear_r();

    // write then read of the same address
    s1_awaddr = 32'h8000_1000; s1_awvalid = 1;
    s1_wdata = 32'h1234_5678; s1_wstrb = 4'hF;
    s1_wlast = 1; s1_wvalid = 1;
    m_awready = 1; m_wready = 1;
    #1;
    chk("c_m_awvalid", m_awvalid, 1);
    chk("c_m_awaddr", m_awaddr, 32'h8000_1000);
    chk("c_m_awid", m_awid, 1);
    chk("c_m_wid", m_wid, 1);
    chk("c_s1_wready", s1_wready, 1);
    step();
    s1_awvalid = 0; s1_wvalid = 0; s1_wlast = 0;
    m_awready = 0; m_wready = 0;
    s1_arvalid = 1; s1_araddr = 32'h8000_1000;
    #1;
    chk("c_s1_held", s1_arready, 0);
    s0_arvalid = 1; s0_arlen = 0;
    #1;
    chk("c_s0_granted", s0_arready, 1);
    step();
    s0_arvalid = 0; m_arready = 1;
    #1;
    chk("c_s0_arid", m_arid, 0);
    step();
    m_arready = 0;
    m_rvalid = 1; m_rlast = 1; m_rid = 0; s0_rready = 1;
    step();
    clear_r();
    #1;
    chk("c_s1_still_held", s1_arready, 0);
    step();
    m_bvalid = 1; m_bid = 1; s1_bready = 1;
    #1;
    chk("c_s1_bvalid", s1_bvalid, 1);
    chk("c_m_bready", m_bready, 1);
    chk("c_s1_held_bcycle", s1_arready, 0);
    step();
    m_bvalid = 0; s1_bready = 0;
    #1;
    chk("c_s1_released", s1_arready, 1);
    step();
    s1_arvalid = 0; m_arready = 1;
    #1;
    chk("c_s1_arid", m_arid, 1);
    chk("c_s1_araddr", m_araddr, 32'h8000_1000);
    step();
    m_arready = 0;
    m_rvalid = 1; m_rlast = 1; m_rid = 1; s1_rready = 1;
    step();
    clear_r();

    // wrong RID on a data read
    s1_arvalid = 1;
    #1;
    step();
    s1_arvalid = 0; m_arready = 1;
    step();
    m_arready = 0;
    m_rvalid = 1; m_rlast = 0; m_rid = 4'h3;
    m_rdata = 32'hDEAD_BEEF; s1_rready = 1;
    #1;
    chk("d_s1_rvalid", s1_rvalid, 1);
    chk("d_s1_rdata", s1_rdata, 32'hDEAD_BEEF);
    chk("d_rid_err_pre", rid_err, 0);
    step();
    m_rvalid = 0;
    #1;
    chk("d_rid_err_set", rid_err, 1);
    m_rvalid = 1; m_rlast = 1; m_rid = 4'h1;
    step();
    clear_r();
    step();
    chk("d_rid_err_sticky", rid_err, 1);

    // reset while in AR_SEND
    s0_arvalid = 1;
    #1;
    step();
    chk("e_m_arvalid", m_arvalid, 1);
    reset = 1;
    #1;
    chk("e_arvalid_gated", m_arvalid, 0);
    chk("e_s0_arready_rst", s0_arready, 0);
    step();
    chk("e_m_arvalid_next", m_arvalid, 0);
    chk("e_s0_arready_next", s0_arready, 0);
    chk("e_s1_arready_next", s1_arready, 0);
    chk("e_rid_err_clr", rid_err, 0);
    reset = 0;
    #1;
    chk("e_idle_after", s0_arready, 1);
    s0_arvalid = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
